return_stack: RTL and testbench
===============================

RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter DEPTH, default 8, number of stack entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter WIDTH, default 12, bit width of each return address, matching the program counter width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-005 push  input  1  push pushData onto the stack this cycle (call instruction).
REQ-006 pop  input  1  remove the top entry this cycle (return instruction).
REQ-007 pushData  input  WIDTH  return address to store, normally PC+1 of the call.
REQ-008 clrErr  input  1  synchronous clear of the sticky overflow and underflow flags.
REQ-009 stackOutput  output  WIDTH  current top-of-stack value, feeding the fetch stage PC-select mux.
REQ-010 count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-011 empty  output  1  high when count = 0.
REQ-012 full  output  1  high when count = DEPTH.
REQ-013 overflow  output  1  sticky; set by a push rejected because the stack is full.
REQ-014 underflow  output  1  sticky; set by a pop attempted on an empty stack.

Function
REQ-015 stackOutput, count, empty, and full are combinational functions of registered state only, with no input-to-output combinational path.
REQ-016 stackOutput equals entry[count-1] when count > 0 and all-zero when count = 0.
REQ-017 A push with pop = 0 and count < DEPTH writes pushData to entry[count] and increments count by 1 at the next edge.
REQ-018 A push with pop = 0 and count = DEPTH writes nothing and leaves count unchanged; overflow is set at the next edge.
REQ-019 A pop with push = 0 and count > 0 decrements count by 1; the vacated entry's contents are don't-care.
REQ-020 A pop with push = 0 and count = 0 leaves all state unchanged except that underflow is set.
REQ-021 Push and pop in the same cycle with count > 0 overwrite entry[count-1] with pushData, leave count unchanged, and set no flag, including when count = DEPTH.
REQ-022 Push and pop in the same cycle with count = 0 perform a normal push (count becomes 1) and set underflow.
REQ-023 clrErr = 1 clears overflow and underflow at the next edge.
REQ-024 If clrErr coincides with a new overflow or underflow event, the event wins and the corresponding flag is 1 after the edge.
REQ-025 Neither push nor pop leaves stackOutput and count unchanged.
REQ-026 The one-cycle latency is as follows: a push at edge N is visible on stackOutput after edge N, so a return in the cycle after a call reads the new address.
REQ-027 Count arithmetic never wraps: count saturates at the boundaries 0 and DEPTH, per REQ-018 and REQ-020.

Reset
REQ-028 While rst = 0, count = 0, empty = 1, full = 0, overflow = 0, underflow = 0, stackOutput = 0, and all entries are cleared to 0, independent of clk.
REQ-029 Asserting rst mid-operation, including during a push/pop cycle, discards all entries immediately; the first edge after rst returns to 1 is processed normally.

Verification
REQ-030 Reset, then push 0x010, 0x020, 0x030 on three edges -> count = 3, stackOutput = 0x030; then pop twice -> stackOutput = 0x010, count = 1.
REQ-031 Push 8 values 0x001..0x008 (DEPTH = 8), then push 0x0FF -> full = 1, count = 8, stackOutput = 0x008, overflow = 1; then pulse clrErr -> overflow = 0.
REQ-032 From empty, pop -> underflow = 1, count = 0, stackOutput = 0; then push+pop with 0x123 -> count = 1, stackOutput = 0x123, underflow = 1.
REQ-033 With count = 8 and top = 0x008, push+pop with 0xABC -> count = 8, stackOutput = 0xABC, overflow = 0.
REQ-034 Push 0x055, then drop rst to 0 between clock edges -> count = 0 and stackOutput = 0 immediately, without waiting for an edge; release rst, push 0x066 -> count = 1, stackOutput = 0x066.
REQ-035 With the stack full, assert push and clrErr together in one cycle -> overflow = 1 after the edge.

Source files
------------

// File: rtl/return_stack.sv
// Hardware return-address stack for call/return prediction.
// Push stores a return address, pop discards the top entry, and push+pop
// together replaces the top entry. Overflow and underflow are sticky error
// flags that clrErr clears. All outputs are derived from registered state
// only, so the fetch-stage PC mux never sees a combinational path from the
// push/pop controls.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     clrErr,
  output logic [WIDTH-1:0]         stackOutput,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_wr_en;
  logic             w_inc;
  logic             w_dec;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  // Decode the push/pop request against the current occupancy.
  // The top index wraps to DEPTH-1 when count = DEPTH because the low AW
  // bits of DEPTH are zero; it is only used when the stack is non-empty.
  // Push+pop on a non-empty stack rewrites the top slot; on an empty stack
  // it behaves as a plain push while still flagging the pop as underflow.
  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == CW'(DEPTH));
    w_top_idx = r_count[AW-1:0] - AW'(1);
    w_wr_en   = push & (pop ? 1'b1 : ~w_full);
    w_wr_idx  = (push & pop & ~w_empty) ? w_top_idx : r_count[AW-1:0];
    w_inc     = push & (pop ? w_empty : ~w_full);
    w_dec     = pop & ~push & ~w_empty;
    w_ovf_evt = push & ~pop & w_full;
    w_unf_evt = pop & w_empty;
  end

  // Entry storage; reset clears every slot so stale addresses never leak out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_wr_idx] <= pushData;
    end
  end

  // Occupancy counter; saturates at 0 and DEPTH because inc/dec are gated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_inc) begin
      r_count <= r_count + CW'(1);
    end else if (w_dec) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Sticky error flags; a new event on the same edge beats clrErr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_evt | (r_overflow  & ~clrErr);
      r_underflow <= w_unf_evt | (r_underflow & ~clrErr);
    end
  end

  // Registered-state-only outputs.
  always_comb begin
    stackOutput = w_empty ? '0 : r_mem[w_top_idx];
    count       = r_count;
    empty       = w_empty;
    full        = w_full;
    overflow    = r_overflow;
    underflow   = r_underflow;
  end

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack (DEPTH = 8, WIDTH = 12).
// Each step drives push/pop/pushData/clrErr on the falling edge, advances a
// behavioural stack model, pushes the predicted post-edge outputs onto
// exp_q, and after the rising edge pops and compares them. Directed
// checks with literal values cover the documented scenarios.
module tb_return_stack;

  localparam int DEPTH = 8;
  localparam int W     = 12;
  localparam int EW    = 4 + 4 + W; // ovf, unf, full, empty, count[3:0], top

  logic          clk;
  logic          rst;
  logic          push;
  logic          pop;
  logic [W-1:0]  pushData;
  logic          clrErr;
  logic [W-1:0]  stackOutput;
  logic [3:0]    count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model state
  logic [W-1:0] m_mem [DEPTH];
  int           m_cnt;
  logic         m_ovf;
  logic         m_unf;

  return_stack #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .pushData    (pushData),
    .clrErr      (clrErr),
    .stackOutput (stackOutput),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  function automatic logic [EW-1:0] model_outputs();
    logic [W-1:0] top;
    top = (m_cnt == 0) ? '0 : m_mem[m_cnt-1];
    return {m_ovf, m_unf, (m_cnt == DEPTH), (m_cnt == 0), 4'(m_cnt), top};
  endfunction

  task automatic model_step(input logic p, input logic q, input logic [W-1:0] d, input logic c);
    logic ovf_evt;
    logic unf_evt;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (p && q) begin
      if (m_cnt == 0) begin
        m_mem[0] = d;
        m_cnt    = 1;
        unf_evt  = 1'b1;
      end else begin
        m_mem[m_cnt-1] = d;
      end
    end else if (p) begin
      if (m_cnt == DEPTH) ovf_evt = 1'b1;
      else begin
        m_mem[m_cnt] = d;
        m_cnt++;
      end
    end else if (q) begin
      if (m_cnt == 0) unf_evt = 1'b1;
      else m_cnt--;
    end
    m_ovf = ovf_evt | (m_ovf & ~c);
    m_unf = unf_evt | (m_unf & ~c);
  endtask

  task automatic compare_outputs(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_top"},   32'(stackOutput), 32'(e[W-1:0]));
    check({tag, "_count"}, 32'(count),       32'(e[W+3:W]));
    check({tag, "_empty"}, 32'(empty),       32'(e[W+4]));
    check({tag, "_full"},  32'(full),        32'(e[W+5]));
    check({tag, "_unf"},   32'(underflow),   32'(e[W+6]));
    check({tag, "_ovf"},   32'(overflow),    32'(e[W+7]));
  endtask

  // Driver: one clocked operation, model prediction queued, outputs checked.
  task automatic step(input string tag, input logic p, input logic q,
                      input logic [W-1:0] d, input logic c);
    @(negedge clk);
    push     = p;
    pop      = q;
    pushData = d;
    clrErr   = c;
    model_step(p, q, d, c);
    exp_q.push_back(model_outputs());
    @(posedge clk);
    #1;
    compare_outputs(tag);
    push     = 1'b0;
    pop      = 1'b0;
    pushData = '0;
    clrErr   = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count),       32'd0);
    check({tag, "_top"},   32'(stackOutput), 32'd0);
    check({tag, "_empty"}, 32'(empty),       32'd1);
    check({tag, "_full"},  32'(full),        32'd0);
    check({tag, "_ovf"},   32'(overflow),    32'd0);
    check({tag, "_unf"},   32'(underflow),   32'd0);
  endtask

  initial begin
    rst      = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    pushData = '0;
    clrErr   = 1'b0;
    model_reset();

    // Reset state, held across a rising edge
    #1;
    check_reset_state("rst0");
    @(posedge clk);
    #1;
    check_reset_state("rst_held");
    @(negedge clk);
    rst = 1'b1;

    // Three pushes, two pops
    step("p10", 1, 0, 12'h010, 0);
    step("p20", 1, 0, 12'h020, 0);
    step("p30", 1, 0, 12'h030, 0);
    check("s1_count", 32'(count), 32'd3);
    check("s1_top",   32'(stackOutput), 32'h030);
    step("pop1", 0, 1, '0, 0);
    step("pop2", 0, 1, '0, 0);
    check("s1_top2",   32'(stackOutput), 32'h010);
    check("s1_count2", 32'(count), 32'd1);
    step("idle", 0, 0, 12'h777, 0);
    check("idle_top", 32'(stackOutput), 32'h010);
    step("pop3", 0, 1, '0, 0);

    // Underflow, then push+pop on empty
    step("unf_pop", 0, 1, '0, 0);
    check("s3_unf",   32'(underflow), 32'd1);
    check("s3_count", 32'(count), 32'd0);
    check("s3_top",   32'(stackOutput), 32'd0);
    step("pp_empty", 1, 1, 12'h123, 0);
    check("s3_count2", 32'(count), 32'd1);
    check("s3_top2",   32'(stackOutput), 32'h123);
    check("s3_unf2",   32'(underflow), 32'd1);
    step("clr_unf", 0, 0, '0, 1);
    check("s3_unf_clr", 32'(underflow), 32'd0);
    step("pop_last", 0, 1, '0, 0);

    // Fill, then overflow
    for (int i = 1; i <= DEPTH; i++) step("fill", 1, 0, W'(i), 0);
    step("ovf_push", 1, 0, 12'h0FF, 0);
    check("s2_full",  32'(full), 32'd1);
    check("s2_count", 32'(count), 32'd8);
    check("s2_top",   32'(stackOutput), 32'h008);
    check("s2_ovf",   32'(overflow), 32'd1);
    step("clr_ovf", 0, 0, '0, 1);
    check("s2_ovf_clr", 32'(overflow), 32'd0);

    // Push+pop while full replaces top, no flag
    step("pp_full", 1, 1, 12'hABC, 0);
    check("s4_count", 32'(count), 32'd8);
    check("s4_top",   32'(stackOutput), 32'hABC);
    check("s4_ovf",   32'(overflow), 32'd0);

    // Overflow event beats a coincident clear
    step("ovf_clr", 1, 0, 12'h111, 1);
    check("s6_ovf", 32'(overflow), 32'd1);
    step("clr2", 0, 0, '0, 1);

    // Asynchronous reset between edges
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_state("rst1");
    @(negedge clk);
    rst = 1'b1;
    step("p55", 1, 0, 12'h055, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("s5_count_async", 32'(count), 32'd0);
    check("s5_top_async",   32'(stackOutput), 32'd0);
    check("s5_empty_async", 32'(empty), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step("p66", 1, 0, 12'h066, 0);
    check("s5_count", 32'(count), 32'd1);
    check("s5_top",   32'(stackOutput), 32'h066);

    // Reset asserted while a push+pop is being driven
    step("p77", 1, 0, 12'h077, 0);
    @(negedge clk);
    push     = 1'b1;
    pop      = 1'b1;
    pushData = 12'h999;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_state("rst_pp");
    @(posedge clk);
    #1;
    check_reset_state("rst_pp_edge");
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
    rst  = 1'b1;

    // Random operations against the model
    for (int i = 0; i < 200; i++) begin
      logic p;
      logic q;
      p = ($urandom_range(0, 9) < 6);
      q = ($urandom_range(0, 9) < 4);
      step("rnd", p, q, W'($urandom_range(0, 4095)), ($urandom_range(0, 7) == 0));
    end

    check("q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
